// File: rtl/rd_width_fifo.sv
// -----------------------------------------------------------------------------
// rd_width_fifo
//   Single-clock synchronous FIFO with wide-to-narrow width conversion. A write
//   word of WR_DATA_WIDTH bits is split into R = WR_DATA_WIDTH/RD_DATA_WIDTH
//   read lanes; lane 0 (the LSBs) is read first, lane R-1 (the MSBs) last.
//   Fill state is tracked in read-word units and every flag/level is decoded
//   combinationally from that registered count.
//
//   Optional build macro RD_FIFO_OUTPUT_REG_EN: adds a second output register
//   after the memory read register (read latency 2 instead of 1).
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   wr_data        write word (WR_DATA_WIDTH)
//   wr_en          write request; accepted when !wr_full
//   wr_full        fewer than R free read slots
//   wr_water_level fill level in write words, ceil(cnt / R)
//   almost_full    wr_water_level >= ALMOST_FULL_NUM
//   rd_data        read word (RD_DATA_WIDTH), registered
//   rd_en          read request; accepted when !rd_empty
//   rd_empty       no read words stored
//   rd_water_level fill level in read words
//   almost_empty   rd_water_level <= ALMOST_EMPTY_NUM
// -----------------------------------------------------------------------------
module rd_width_fifo #(
  parameter int WR_DEPTH_WIDTH   = 10,
  parameter int WR_DATA_WIDTH    = 128,
  parameter int RD_DEPTH_WIDTH   = 12,
  parameter int RD_DATA_WIDTH    = 32,
  parameter int ALMOST_FULL_NUM  = 252,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  input  logic                      rd_en,
  output logic                      rd_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      almost_empty
);

  localparam int R          = WR_DATA_WIDTH / RD_DATA_WIDTH;
  localparam int RATIO_LOG2 = RD_DEPTH_WIDTH - WR_DEPTH_WIDTH;
  localparam int DEPTH      = 2 ** RD_DEPTH_WIDTH;

  localparam logic [RD_DEPTH_WIDTH:0] CNT_R    = (RD_DEPTH_WIDTH+1)'(R);
  localparam logic [RD_DEPTH_WIDTH:0] CNT_R_M1 = (RD_DEPTH_WIDTH+1)'(R - 1);
  localparam logic [RD_DEPTH_WIDTH:0] FULL_TH  = (RD_DEPTH_WIDTH+1)'(DEPTH - R);
  localparam logic [RD_DEPTH_WIDTH:0] AE_TH    = (RD_DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
  localparam logic [WR_DEPTH_WIDTH:0] AF_TH    = (WR_DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);

  logic [RD_DATA_WIDTH-1:0]  mem [DEPTH];
  logic [RD_DEPTH_WIDTH:0]   wr_ptr;     // slot pointer plus wrap bit, steps by R
  logic [RD_DEPTH_WIDTH:0]   rd_ptr;     // slot pointer plus wrap bit, steps by 1
  logic [RD_DEPTH_WIDTH:0]   cnt;        // stored read words, 0..DEPTH
  logic [RD_DEPTH_WIDTH:0]   cnt_round;  // cnt + R - 1, for the ceiling divide
  logic [RD_DATA_WIDTH-1:0]  rd_q;
  logic                      wr_acc;
  logic                      rd_acc;

  assign wr_acc = wr_en && !wr_full;
  assign rd_acc = rd_en && !rd_empty;

  // Flags and levels: pure decode of the registered count.
  assign rd_water_level = cnt;
  assign cnt_round      = cnt + CNT_R_M1;
  assign wr_water_level = (WR_DEPTH_WIDTH+1)'(cnt_round >> RATIO_LOG2);
  assign rd_empty       = (cnt == '0);
  assign wr_full        = (cnt > FULL_TH);
  assign almost_full    = (wr_water_level >= AF_TH);
  assign almost_empty   = (cnt <= AE_TH);

  // Pointers and count.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CNT_R;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CNT_R;
        2'b01:   cnt <= cnt - 1'b1;
        2'b11:   cnt <= cnt + CNT_R_M1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage. The write pointer only ever moves in steps of R from zero, so a
  // write word always lands in R aligned slots and never straddles the wrap.
  // NOTE: the array has no reset; a reset loop over every slot would stop it
  // mapping onto RAM, and cnt already marks every slot as invalid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < R; i++) begin
        mem[wr_ptr[RD_DEPTH_WIDTH-1:0] + RD_DEPTH_WIDTH'(i)] <=
          wr_data[i*RD_DATA_WIDTH +: RD_DATA_WIDTH];
      end
    end
  end

  // Memory read register: only loads on an accepted read, so rd_data holds
  // across idle cycles and ignored reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else if (rd_acc) rd_q <= mem[rd_ptr[RD_DEPTH_WIDTH-1:0]];
  end

`ifdef RD_FIFO_OUTPUT_REG_EN
  logic [RD_DATA_WIDTH-1:0] rd_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q2 <= '0;
    else        rd_q2 <= rd_q;
  end

  assign rd_data = rd_q2;
`else
  assign rd_data = rd_q;
`endif

  // The wrap-bit pointers and the count are redundant encodings of one fact.
  cnt_matches_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
    cnt == wr_ptr - rd_ptr);

endmodule

// File: tb/tb_rd_width_fifo.sv
// -----------------------------------------------------------------------------
// tb_rd_width_fifo
//   Directed bench for rd_width_fifo at default parameters (R = 4). The driver
//   pushes each expected read word into a scoreboard queue as it issues rd_en;
//   an independent monitor pops and compares rd_data after the read latency.
//   Flags and levels are checked every cycle against an expected fill level.
// -----------------------------------------------------------------------------
module tb_rd_width_fifo;

`ifdef RD_FIFO_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic [127:0] wr_data;
  logic         wr_en;
  logic         wr_full;
  logic [10:0]  wr_water_level;
  logic         almost_full;
  logic [31:0]  rd_data;
  logic         rd_en;
  logic         rd_empty;
  logic [12:0]  rd_water_level;
  logic         almost_empty;

  rd_width_fifo dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .rd_data        (rd_data),
    .rd_en          (rd_en),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          lvl   = 0;          // expected fill level in read words
  logic [31:0] model_q [$];        // lanes stored in the FIFO, oldest first
  logic [31:0] exp_q   [$];        // expected rd_data per issued read
  logic [31:0] last_rd = '0;       // value rd_data must hold on ignored reads
  logic [1:0]  pend;               // rd_en history for the monitor

  localparam logic [127:0] ALL1 = {128{1'b1}};

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    check("rd_water_level", 128'(rd_water_level), 128'(lvl));
    check("wr_water_level", 128'(wr_water_level), 128'((lvl + 3) / 4));
    check("rd_empty",       128'(rd_empty),       128'(lvl == 0));
    check("wr_full",        128'(wr_full),        128'(lvl > 4092));
    check("almost_full",    128'(almost_full),    128'(((lvl + 3) / 4) >= 252));
    check("almost_empty",   128'(almost_empty),   128'(lvl <= 4));
  endtask

  // One clock of stimulus. w_ok / r_ok state whether the write / read is
  // expected to be accepted at this edge (known from the directed sequence).
  task automatic cycle(input logic we, input logic [127:0] wd, input logic re,
                       input bit w_ok, input bit r_ok);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    if (we && w_ok)
      for (int l = 0; l < 4; l++) model_q.push_back(wd[l*32 +: 32]);
    if (re) begin
      if (r_ok) last_rd = model_q.pop_front();
      exp_q.push_back(last_rd);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    lvl   = lvl + (w_ok ? 4 : 0) - (r_ok ? 1 : 0);
    check_flags();
  endtask

  // Monitor: rd_en sampled at edge k shows up on rd_data after edge k+LAT-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= {pend[0], rd_en};
  end

  always @(negedge clk) begin
    if (rst_n && pend[LAT-1]) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_data: unexpected read, got %0h expected none", rd_data);
      end else begin
        check("rd_data", 128'(rd_data), 128'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst rd_data", 128'(rd_data), 128'(0));
    check_flags();
    rst_n = 1'b1;
    @(negedge clk);
    check_flags();

    // Read while empty: ignored, rd_data stays 0.
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Fill: 1025 writes, the last one dropped because the FIFO is full.
    for (int j = 0; j < 1025; j++)
      cycle(1'b1, ALL1 - 128'(j), 1'b0, j < 1024, 1'b0);
    check("fill wr_level",    128'(wr_water_level), 128'(1024));
    check("fill rd_level",    128'(rd_water_level), 128'(4096));
    check("fill wr_full",     128'(wr_full),        128'(1));
    check("fill almost_full", 128'(almost_full),    128'(1));

    // Drain: 4097 reads, the last one ignored with rd_data holding.
    for (int i = 0; i < 4097; i++)
      cycle(1'b0, '0, 1'b1, 1'b0, i < 4096);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("drain rd_empty", 128'(rd_empty), 128'(1));

    // Partial drain of one write word.
    cycle(1'b1, 128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("partial rd_level", 128'(rd_water_level), 128'(3));
    check("partial wr_level", 128'(wr_water_level), 128'(1));
    check("partial wr_full",  128'(wr_full),        128'(0));

    // Bring level to 8, then a simultaneous read and write.
    cycle(1'b1, 128'h13131313_12121212_11111111_10101010, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 128'h23232323_22222222_21212121_20202020, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("pre-simul rd_level", 128'(rd_water_level), 128'(8));
    cycle(1'b1, 128'h33333333_32323232_31313131_30303030, 1'b1, 1'b1, 1'b1);
    check("simul rd_level", 128'(rd_water_level), 128'(11));
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Balanced stream long enough to carry both pointers across the wrap.
    for (int k = 0; k < 1030; k++) begin
      cycle(1'b1, {4{32'(k)}} ^ 128'hC3000000_C2000000_C1000000_C0000000,
            1'b1, 1'b1, 1'b1);
      repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    end
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Reach level 100, then reset asynchronously between clock edges.
    for (int k = 0; k < 23; k++)
      cycle(1'b1, {4{32'(k + 32'h5000)}}, 1'b0, 1'b1, 1'b0);
    check("pre-reset rd_level", 128'(rd_water_level), 128'(100));
    #2 rst_n = 1'b0;
    #1;
    check("async rst rd_data",      128'(rd_data),        128'(0));
    check("async rst rd_empty",     128'(rd_empty),       128'(1));
    check("async rst almost_empty", 128'(almost_empty),   128'(1));
    check("async rst wr_full",      128'(wr_full),        128'(0));
    check("async rst almost_full",  128'(almost_full),    128'(0));
    check("async rst rd_level",     128'(rd_water_level), 128'(0));
    check("async rst wr_level",     128'(wr_water_level), 128'(0));
    lvl     = 0;
    last_rd = '0;
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round trip after reset.
    cycle(1'b1, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 1'b0, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("post-reset rd_empty", 128'(rd_empty), 128'(1));
    check("scoreboard drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
